// File: rtl/axilite_noc_request.sv
// AXI-lite slave that turns single reads and writes into Piton NoC non-cacheable
// load/store request packets, serialized one 64-bit flit at a time.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif

module axilite_noc_request #(
  parameter int          AXI_LITE_DATA_WIDTH = 64,
  parameter int          AXI_LITE_ADDR_WIDTH = 64,
  parameter bit          SWAP_ENDIANESS      = 1'b0,
  parameter logic [13:0] DST_CHIPID          = 14'd0,
  parameter logic [7:0]  DST_X               = 8'd0,
  parameter logic [7:0]  DST_Y               = 8'd0,
  parameter logic [13:0] SRC_CHIPID          = 14'd0,
  parameter logic [7:0]  SRC_X               = 8'd0,
  parameter logic [7:0]  SRC_Y               = 8'd0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                             s_axi_arvalid,
  output logic                             s_axi_arready,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                             s_axi_awvalid,
  output logic                             s_axi_awready,
  input  logic [AXI_LITE_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_LITE_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                             s_axi_wvalid,
  output logic                             s_axi_wready,
  output logic                             noc_valid_out,
  output logic [`NOC_DATA_WIDTH-1:0]       noc_data_out,
  input  logic                             noc_ready_in
);
  localparam int NOC_W          = `NOC_DATA_WIDTH;
  localparam int PHY_ADDR_WIDTH = 40;
  localparam int NUM_DATA       = AXI_LITE_DATA_WIDTH / NOC_W;
  localparam int CNT_W          = (NUM_DATA > 1) ? $clog2(NUM_DATA) : 1;
  localparam logic [CNT_W-1:0] LAST_FLIT = CNT_W'(NUM_DATA - 1);
  localparam logic [7:0] MSG_TYPE_NC_LOAD_REQ  = 8'd14;
  localparam logic [7:0] MSG_TYPE_NC_STORE_REQ = 8'd15;
  localparam logic [7:0] LOAD_LEN  = 8'd2;
  localparam logic [7:0] STORE_LEN = 8'(2 + NUM_DATA);
  localparam logic [2:0] DATA_SIZE = (AXI_LITE_DATA_WIDTH == 64)  ? 3'b100 :
                                     (AXI_LITE_DATA_WIDTH == 128) ? 3'b101 :
                                     (AXI_LITE_DATA_WIDTH == 256) ? 3'b110 : 3'b111;

  // state | meaning
  // IDLE  | waiting for an eligible AR or AW+W; readies only here
  // HDR0  | header0: destination, length, type, mshrid
  // HDR1  | header1: physical address and size code
  // HDR2  | header2: source; loads finish here
  // DATA  | store payload, low 64 bits first
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, DATA} state_t;

  state_t                           state, state_next;
  logic                             rr_read_first;
  logic [7:0]                       mshrid_cnt, mshrid_q;
  logic [AXI_LITE_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_LITE_DATA_WIDTH-1:0]   data_q;
  logic                             is_store_q;
  logic [CNT_W-1:0]                 flit_cnt;
  logic                             read_elig, write_elig, grant_read, grant_write;
  logic                             fire;
  logic [NOC_W-1:0]                 data_flit;
  logic                             unused_ok;

  function automatic logic [NOC_W-1:0] byte_swap(input logic [NOC_W-1:0] d);
    logic [NOC_W-1:0] r;
    for (int b = 0; b < NOC_W/8; b++) r[8*b +: 8] = d[NOC_W-8-8*b +: 8];
    return r;
  endfunction

  // Reset gates the readies so no handshake is ever reported that the core drops.
  assign read_elig   = s_axi_arvalid;
  assign write_elig  = s_axi_awvalid && s_axi_wvalid;
  assign grant_read  = (state == IDLE) && !rst && read_elig && (!write_elig || rr_read_first);
  assign grant_write = (state == IDLE) && !rst && write_elig && !grant_read;
  assign fire        = noc_valid_out && noc_ready_in;
  assign data_flit   = data_q[flit_cnt*NOC_W +: NOC_W];
  assign unused_ok   = ^{s_axi_wstrb, addr_q};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (grant_read || grant_write) state_next = HDR0;
      HDR0: if (fire) state_next = HDR1;
      HDR1: if (fire) state_next = HDR2;
      HDR2: if (fire) state_next = is_store_q ? DATA : IDLE;
      DATA: if (fire && flit_cnt == LAST_FLIT) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = grant_read;
    s_axi_awready = grant_write;
    s_axi_wready  = grant_write;
    noc_valid_out = 1'b0;
    noc_data_out  = '0;
    case (state)
      HDR0: begin
        noc_valid_out = 1'b1;
        noc_data_out  = {DST_CHIPID, DST_X, DST_Y, 4'b0,
                         is_store_q ? STORE_LEN : LOAD_LEN,
                         is_store_q ? MSG_TYPE_NC_STORE_REQ : MSG_TYPE_NC_LOAD_REQ,
                         mshrid_q, 6'b0};
      end
      HDR1: begin
        noc_valid_out = 1'b1;
        noc_data_out  = {8'b0, addr_q[PHY_ADDR_WIDTH-1:0], DATA_SIZE, 13'b0};
      end
      HDR2: begin
        noc_valid_out = 1'b1;
        noc_data_out  = {SRC_CHIPID, SRC_X, SRC_Y, 34'b0};
      end
      DATA: begin
        noc_valid_out = 1'b1;
        noc_data_out  = SWAP_ENDIANESS ? byte_swap(data_flit) : data_flit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_read_first <= 1'b1;
      mshrid_cnt    <= '0;
      mshrid_q      <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      is_store_q    <= 1'b0;
      flit_cnt      <= '0;
    end else begin
      if (grant_read || grant_write) begin
        addr_q        <= grant_read ? s_axi_araddr : s_axi_awaddr;
        data_q        <= s_axi_wdata;
        is_store_q    <= grant_write;
        mshrid_q      <= mshrid_cnt;
        mshrid_cnt    <= mshrid_cnt + 8'd1;
        rr_read_first <= grant_write;
      end
      if (state == HDR2 && fire)      flit_cnt <= '0;
      else if (state == DATA && fire) flit_cnt <= flit_cnt + 1'b1;
    end
  end
endmodule
